// File: rtl/mem_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM read-channel arbiter.
// Optional feature macro: ICACHE_REFILL_LOCK_EN (icache line-refill lock).
package mem_rd_arbiter_pkg;

   localparam int DATA_LEN = 32;
   localparam int BEATS    = 4;
   localparam int BEAT_W   = $clog2(BEATS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [2:0] RESP_OKAY = 3'h0;
   localparam logic [2:0] RESP_ERR  = 3'h2;

   localparam logic REQ_ICACHE = 1'b0;
   localparam logic REQ_LSU    = 1'b1;

endpackage

// File: rtl/mem_rd_arbiter_rr_arb2.sv
// Combinational two-way round-robin winner select; lock restricts the choice to the icache.
module rr_arb2
   import mem_rd_arbiter_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last,
   input  logic       lock,
   output logic       grant_valid,
   output logic       grant
);

   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant_valid = 1'b0;
      grant       = REQ_ICACHE;
      if (lock) begin
         grant_valid = valid[REQ_ICACHE];
      end else begin
         grant_valid = |valid;
         if (&valid)
            grant = ~last;
         else if (valid[REQ_LSU])
            grant = REQ_LSU;
      end
   end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one SRAM read port between icache refill (requester 0) and LSU (requester 1).
// Optional feature macro: ICACHE_REFILL_LOCK_EN keeps the port with the icache for a whole line refill.
module mem_rd_arbiter
   import mem_rd_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                icache_arvalid,
   output logic                icache_arready,
   input  logic [DATA_LEN-1:0] icache_raddr,
   output logic                icache_rvalid,
   input  logic                icache_rready,
   output logic [DATA_LEN-1:0] icache_rdata,
   output logic [2:0]          icache_rresp,
   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   input  logic [DATA_LEN-1:0] lsu_raddr,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,
   output logic [DATA_LEN-1:0] lsu_rdata,
   output logic [2:0]          lsu_rresp,
   output logic                sram_arvalid,
   input  logic                sram_arready,
   output logic [DATA_LEN-1:0] sram_raddr,
   input  logic                sram_rvalid,
   output logic                sram_rready,
   input  logic [DATA_LEN-1:0] sram_rdata,
   input  logic [2:0]          sram_rresp
);

   state_t state, state_nxt;
   logic   owner, last, lock;
   logic   gnt_vld, gnt;
   logic   ar_hs, r_hs;

   rr_arb2 u_rr_arb2 (
      .valid       ({lsu_arvalid, icache_arvalid}),
      .last        (last),
      .lock        (lock),
      .grant_valid (gnt_vld),
      .grant       (gnt)
   );

   assign ar_hs = (state == IDLE) && gnt_vld;
   assign r_hs  = (state == DATA) && sram_rvalid && sram_rready;

   // NOTE: state-holding processes use non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ar_hs) state_nxt = ADDR;
         ADDR:    if (sram_arready) state_nxt = DATA;
         DATA:    if (r_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sram_raddr <= '0;
         owner      <= REQ_ICACHE;
         last       <= REQ_LSU;
      end else if (ar_hs) begin
         sram_raddr <= (gnt == REQ_LSU) ? lsu_raddr : icache_raddr;
         owner      <= gnt;
         last       <= gnt;
      end
   end

`ifdef ICACHE_REFILL_LOCK_EN
   logic [BEAT_W-1:0] beat_cnt;

   // A line-aligned icache grant opens a refill; the BEATS-th icache data beat closes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock     <= 1'b0;
         beat_cnt <= '0;
      end else begin
         if (ar_hs && gnt == REQ_ICACHE && !lock && icache_raddr[3:2] == 2'b00)
            lock <= 1'b1;
         if (r_hs && owner == REQ_ICACHE && lock) begin
            if (beat_cnt == BEAT_W'(BEATS - 1)) begin
               lock     <= 1'b0;
               beat_cnt <= '0;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign lock = 1'b0;
`endif

   always_comb begin
      icache_arready = 1'b0;
      lsu_arready    = 1'b0;
      sram_arvalid   = 1'b0;
      sram_rready    = 1'b0;
      icache_rvalid  = 1'b0;
      icache_rdata   = '0;
      icache_rresp   = RESP_OKAY;
      lsu_rvalid     = 1'b0;
      lsu_rdata      = '0;
      lsu_rresp      = RESP_OKAY;
      case (state)
         IDLE: begin
            icache_arready = gnt_vld && (gnt == REQ_ICACHE);
            lsu_arready    = gnt_vld && (gnt == REQ_LSU);
         end
         ADDR: sram_arvalid = 1'b1;
         DATA: begin
            if (owner == REQ_LSU) begin
               sram_rready = lsu_rready;
               lsu_rvalid  = sram_rvalid;
               lsu_rdata   = sram_rdata;
               lsu_rresp   = sram_rresp;
            end else begin
               sram_rready   = icache_rready;
               icache_rvalid = sram_rvalid;
               icache_rdata  = sram_rdata;
               icache_rresp  = sram_rresp;
            end
         end
         default: ;
      endcase
   end

endmodule
